// File: rtl/sram_phy_pkg.sv
// Shared types and geometry for the SWORD4 asynchronous SRAM word controller.
package sram_phy_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned SRAM_AW   = 20;
  localparam int unsigned SRAM_DW   = 48;
  localparam int unsigned CHIP_DW   = 16;
  localparam int unsigned NUM_CHIPS = 3;

endpackage

// File: rtl/sram_data_io.sv
// 48-bit SRAM data pad buffer: one output enable per 16-bit chip lane,
// read data taken straight off the pads.
module sram_data_io
  import sram_phy_pkg::*;
(
  input  logic [NUM_CHIPS-1:0] oe,
  input  logic [SRAM_DW-1:0]   wr_data,
  output logic [SRAM_DW-1:0]   rd_data,
  inout  wire  [SRAM_DW-1:0]   pad
);

  for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_lane
    assign pad[c*CHIP_DW +: CHIP_DW] = oe[c] ? wr_data[c*CHIP_DW +: CHIP_DW] : 'z;
  end

  assign rd_data = pad;

endmodule

// File: rtl/sram_phy_ctrl.sv
// Word-level controller for the SWORD4 async SRAM (chips 0/1 data, chip 2 idle).
// Optional SRAM_BOUND_CHECK_EN: suppress out-of-range accesses and flag addr_err.
module sram_phy_ctrl
  import sram_phy_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                 clkCPU,
  input  logic                 rst_n,
  input  logic                 wb_stb,
  input  logic [31:0]          wb_addr,
  input  logic [3:0]           wb_we,
  input  logic [31:0]          wb_din,
  output logic [31:0]          wb_dout,
  output logic                 wb_nak,
  output logic [2:0]           sram_ce_n,
  output logic [2:0]           sram_oe_n,
  output logic [2:0]           sram_we_n,
  output logic [2:0]           sram_ub_n,
  output logic [2:0]           sram_lb_n,
  output logic [SRAM_AW-1:0]   sram_addr,
  inout  wire  [SRAM_DW-1:0]   sram_data,
  output logic                 addr_err
);

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);
  localparam logic [2:0] STB_OFF  = 3'b111;
  localparam logic [2:0] STB_ON   = 3'b100;

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [SRAM_AW-1:0] addr_nx;
  logic [2:0]         ce_nx, oe_nx, we_nx, ub_nx, lb_nx;
  logic [31:0]        wdata, wdata_nx, dout_nx;
  logic               drv, drv_nx, nak_nx, wr, wr_nx, oob, oob_nx;
  logic               accept, req_oob;
  logic [SRAM_DW-1:0] rd_bus;

  assign accept = (state == IDLE) && wb_stb && !wb_nak;

`ifdef SRAM_BOUND_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^{wb_addr[1:0], rd_bus[47:32]};
  assign req_oob     = |wb_addr[31:22];

  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n)                 addr_err <= 1'b0;
    else if (accept && req_oob) addr_err <= 1'b1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{wb_addr[31:22], wb_addr[1:0], rd_bus[47:32]};
  assign req_oob     = 1'b0;
  assign addr_err    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = sram_addr;
    ce_nx    = sram_ce_n;
    oe_nx    = sram_oe_n;
    we_nx    = sram_we_n;
    ub_nx    = sram_ub_n;
    lb_nx    = sram_lb_n;
    wdata_nx = wdata;
    drv_nx   = drv;
    nak_nx   = wb_nak;
    wr_nx    = wr;
    oob_nx   = oob;
    dout_nx  = wb_dout;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ACCESS;
          cnt_nx   = CNT_INIT;
          addr_nx  = wb_addr[21:2];
          nak_nx   = 1'b1;
          wr_nx    = |wb_we;
          oob_nx   = req_oob;
          wdata_nx = wb_din;
          // Out-of-range accesses keep every pin idle but still run the busy timing.
          if (!req_oob) begin
            ce_nx = STB_ON;
            if (|wb_we) begin
              lb_nx  = {1'b1, ~wb_we[2], ~wb_we[0]};
              ub_nx  = {1'b1, ~wb_we[3], ~wb_we[1]};
              drv_nx = 1'b1;
            end else begin
              oe_nx = STB_ON;
              ub_nx = STB_ON;
              lb_nx = STB_ON;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          state_nx = IDLE;
          nak_nx   = 1'b0;
          ce_nx    = STB_OFF;
          oe_nx    = STB_OFF;
          we_nx    = STB_OFF;
          ub_nx    = STB_OFF;
          lb_nx    = STB_OFF;
          drv_nx   = 1'b0;
          if (!wr) dout_nx = oob ? '0 : rd_bus[31:0];
        end else begin
          cnt_nx = cnt - 4'd1;
          if (wr && !oob) we_nx = STB_ON;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clkCPU or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_addr <= '0;
      sram_ce_n <= '1;
      sram_oe_n <= '1;
      sram_we_n <= '1;
      sram_ub_n <= '1;
      sram_lb_n <= '1;
      wdata     <= '0;
      drv       <= 1'b0;
      wb_nak    <= 1'b0;
      wr        <= 1'b0;
      oob       <= 1'b0;
      wb_dout   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sram_addr <= addr_nx;
      sram_ce_n <= ce_nx;
      sram_oe_n <= oe_nx;
      sram_we_n <= we_nx;
      sram_ub_n <= ub_nx;
      sram_lb_n <= lb_nx;
      wdata     <= wdata_nx;
      drv       <= drv_nx;
      wb_nak    <= nak_nx;
      wr        <= wr_nx;
      oob       <= oob_nx;
      wb_dout   <= dout_nx;
    end
  end

  sram_data_io u_io (
    .oe      ({1'b0, drv, drv}),
    .wr_data ({16'h0000, wdata}),
    .rd_data (rd_bus),
    .pad     (sram_data)
  );

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// Directed bench for sram_phy_ctrl: vector table plus reset, burst, bound and slow-access sequences.
module tb_sram_phy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_addr = '0;
  logic [3:0]  wb_we = '0;
  logic [31:0] wb_din = '0;
  logic [31:0] wb_dout;
  logic        wb_nak, addr_err;
  logic [2:0]  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [19:0] sram_addr;
  wire  [47:0] sram_data;

  logic        stb5 = 1'b0;
  logic [31:0] addr5 = '0;
  logic [31:0] dout5;
  logic        nak5, err5;
  logic [2:0]  ce5, oe5, we5, ub5, lb5;
  logic [19:0] saddr5;
  wire  [47:0] sram_data5;

  int n_chk = 0;
  int n_fail = 0;
  int contention = 0;
  int chip2_bad = 0;

  always #5 clk = ~clk;

  sram_phy_ctrl #(.ACCESS_CYCLES(2)) dut (
    .clkCPU(clk), .rst_n(rst_n), .wb_stb(wb_stb), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_din(wb_din), .wb_dout(wb_dout), .wb_nak(wb_nak), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .sram_addr(sram_addr), .sram_data(sram_data), .addr_err(addr_err)
  );

  sram_phy_ctrl #(.ACCESS_CYCLES(5)) dut5 (
    .clkCPU(clk), .rst_n(rst_n), .wb_stb(stb5), .wb_addr(addr5), .wb_we(4'h0),
    .wb_din(32'h0), .wb_dout(dout5), .wb_nak(nak5), .sram_ce_n(ce5),
    .sram_oe_n(oe5), .sram_we_n(we5), .sram_ub_n(ub5),
    .sram_lb_n(lb5), .sram_addr(saddr5), .sram_data(sram_data5), .addr_err(err5)
  );

  // SRAM model for the main instance: reads are combinational, writes land while we_n is low.
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic rd0, rd1;
  assign rd0 = !sram_ce_n[0] && !sram_oe_n[0] && sram_we_n[0];
  assign rd1 = !sram_ce_n[1] && !sram_oe_n[1] && sram_we_n[1];
  assign sram_data[15:0]  = rd0 ? mem0[sram_addr[9:0]] : 'z;
  assign sram_data[31:16] = rd1 ? mem1[sram_addr[9:0]] : 'z;

  always @(negedge clk) begin
    if (!sram_ce_n[0] && !sram_we_n[0]) begin
      if (!sram_lb_n[0]) mem0[sram_addr[9:0]][7:0]  <= sram_data[7:0];
      if (!sram_ub_n[0]) mem0[sram_addr[9:0]][15:8] <= sram_data[15:8];
    end
    if (!sram_ce_n[1] && !sram_we_n[1]) begin
      if (!sram_lb_n[1]) mem1[sram_addr[9:0]][7:0]  <= sram_data[23:16];
      if (!sram_ub_n[1]) mem1[sram_addr[9:0]][15:8] <= sram_data[31:24];
    end
    if ((rd0 || rd1) && dut.drv) contention <= contention + 1;
    if (sram_ce_n[2] !== 1'b1 || sram_oe_n[2] !== 1'b1 || sram_we_n[2] !== 1'b1 ||
        sram_ub_n[2] !== 1'b1 || sram_lb_n[2] !== 1'b1)
      chip2_bad <= chip2_bad + 1;
  end

  assign sram_data5[31:0] = (!ce5[0] && !oe5[0]) ? {12'h5A5, saddr5} : 'z;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] d;
    logic [19:0] e_addr;
    logic [2:0]  e_ub;
    logic [2:0]  e_lb;
    int          e_we;
    int          e_oe;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] strobes();
    return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
  endfunction

  // Called at a negedge with the controller idle; returns at the negedge where wb_nak has fallen.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                         output logic [19:0] o_addr, output logic [2:0] o_ce,
                         output logic [2:0] o_ub, output logic [2:0] o_lb,
                         output int busy, output int we_c, output int oe_c,
                         output logic [31:0] o_dout, output logic [15:0] o_idle);
    wb_addr = a;
    wb_we   = we;
    wb_din  = d;
    wb_stb  = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0;
    o_addr = sram_addr;
    o_ce   = sram_ce_n;
    o_ub   = sram_ub_n;
    o_lb   = sram_lb_n;
    busy = 0; we_c = 0; oe_c = 0;
    for (int t = 0; t < 40 && wb_nak; t++) begin
      busy++;
      if (sram_we_n[1:0] == 2'b00) we_c++;
      if (sram_oe_n[1:0] == 2'b00) oe_c++;
      @(negedge clk);
    end
    o_dout = wb_dout;
    o_idle = {strobes(), dut.drv};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] r_addr;
    logic [2:0]  r_ce, r_ub, r_lb;
    int          busy, we_c, oe_c;
    logic [31:0] r_dout;
    logic [15:0] r_idle;
    logic [31:0] b_addr;
    logic [31:0] b_exp;
    int          issued, cyc, last, bad_gap;
    logic        pending, acc;
    int          p5_busy, p5_oe;
    logic [31:0] p5_prev;

    vecs[0]  = '{32'h0000_0010, 4'hF, 32'h1234_5678, 20'h00004, 3'b100, 3'b100, 1, 0, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 20'h00004, 3'b100, 3'b100, 0, 2, 32'h1234_5678};
    vecs[2]  = '{32'h0000_0010, 4'h4, 32'hAABB_CCDD, 20'h00004, 3'b111, 3'b101, 1, 0, 32'h1234_5678};
    vecs[3]  = '{32'h0000_0010, 4'h0, 32'h0000_0000, 20'h00004, 3'b100, 3'b100, 0, 2, 32'h12BB_5678};
    vecs[4]  = '{32'h0000_0024, 4'hF, 32'h1122_3344, 20'h00009, 3'b100, 3'b100, 1, 0, 32'h12BB_5678};
    vecs[5]  = '{32'h0000_0024, 4'h3, 32'hCAFE_F00D, 20'h00009, 3'b110, 3'b110, 1, 0, 32'h12BB_5678};
    vecs[6]  = '{32'h0000_0024, 4'h8, 32'h7700_0000, 20'h00009, 3'b101, 3'b111, 1, 0, 32'h12BB_5678};
    vecs[7]  = '{32'h0000_0024, 4'h0, 32'h0000_0000, 20'h00009, 3'b100, 3'b100, 0, 2, 32'h7722_F00D};
    vecs[8]  = '{32'h003F_FFFC, 4'hF, 32'hDEAD_BEEF, 20'hFFFFF, 3'b100, 3'b100, 1, 0, 32'h7722_F00D};
    vecs[9]  = '{32'h003F_FFFC, 4'h0, 32'h0000_0000, 20'hFFFFF, 3'b100, 3'b100, 0, 2, 32'hDEAD_BEEF};
    vecs[10] = '{32'h0000_0010, 4'h0, 32'h0000_0000, 20'h00004, 3'b100, 3'b100, 0, 2, 32'h12BB_5678};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_strobes", 64'(strobes()), 64'h7FFF);
    chk("reset_nak", 64'(wb_nak), 64'h0);
    chk("reset_dout", 64'(wb_dout), 64'h0);
    chk("reset_addr", 64'(sram_addr), 64'h0);
    chk("reset_addr_err", 64'(addr_err), 64'h0);
    chk("reset_bus_released", 64'(dut.drv), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted one edge into a write aborts it immediately
    wb_addr = 32'h0000_0080; wb_we = 4'hF; wb_din = 32'h55AA_55AA; wb_stb = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0;
    chk("midwr_nak_set", 64'(wb_nak), 64'h1);
    @(posedge clk);
    #1;
    chk("midwr_we_low", 64'(sram_we_n), 64'h4);
    rst_n = 1'b0;
    #1;
    chk("midwr_strobes_off", 64'(strobes()), 64'h7FFF);
    chk("midwr_bus_released", 64'(dut.drv), 64'h0);
    chk("midwr_nak_clear", 64'(wb_nak), 64'h0);
    chk("midwr_dout_kept", 64'(wb_dout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int unsigned i = 0; i < 11; i++) begin
      run_txn(vecs[i].a, vecs[i].we, vecs[i].d, r_addr, r_ce, r_ub, r_lb, busy, we_c, oe_c, r_dout, r_idle);
      chk($sformatf("v%0d_addr", i), 64'(r_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d_ce", i), 64'(r_ce), 64'h4);
      chk($sformatf("v%0d_ub", i), 64'(r_ub), 64'(vecs[i].e_ub));
      chk($sformatf("v%0d_lb", i), 64'(r_lb), 64'(vecs[i].e_lb));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'd2);
      chk($sformatf("v%0d_we_cycles", i), 64'(we_c), 64'(vecs[i].e_we));
      chk($sformatf("v%0d_oe_cycles", i), 64'(oe_c), 64'(vecs[i].e_oe));
      chk($sformatf("v%0d_dout", i), 64'(r_dout), 64'(vecs[i].e_dout));
      chk($sformatf("v%0d_idle_after", i), 64'(r_idle), 64'hFFFE);
    end

    // Burst: preload 16 words, then read them back with wb_stb held high
    for (int unsigned k = 0; k < 16; k++)
      run_txn(32'h100 + 32'(k * 4), 4'hF, 32'h0A0B_0000 + 32'(k) * 32'h0001_0011,
              r_addr, r_ce, r_ub, r_lb, busy, we_c, oe_c, r_dout, r_idle);
    b_addr = 32'h100; wb_we = 4'h0; wb_addr = b_addr; wb_stb = 1'b1;
    issued = 0; cyc = 0; last = 0; bad_gap = 0; pending = 1'b0; acc = 1'b0; b_exp = '0;
    for (int t = 0; t < 200 && (issued < 16 || pending); t++) begin
      if (!wb_nak) begin
        if (pending) begin
          chk($sformatf("burst_dout_%0d", issued - 1), 64'(wb_dout), 64'(b_exp));
          pending = 1'b0;
        end
        if (issued < 16) begin
          if (issued > 0 && cyc - last != 3) bad_gap++;
          last = cyc;
          b_exp = 32'h0A0B_0000 + ((b_addr - 32'h100) >> 2) * 32'h0001_0011;
          pending = 1'b1;
          issued++;
          acc = 1'b1;
        end else begin
          wb_stb = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        b_addr = b_addr + 4;
        wb_addr = b_addr;
        acc = 1'b0;
      end
    end
    wb_stb = 1'b0;
    chk("burst_completed", 64'(issued), 64'd16);
    chk("burst_spacing", 64'(bad_gap), 64'd0);
    @(negedge clk);

`ifdef SRAM_BOUND_CHECK_EN
    run_txn(32'h0040_0000, 4'h0, 32'h0, r_addr, r_ce, r_ub, r_lb, busy, we_c, oe_c, r_dout, r_idle);
    chk("oob_ce_idle", 64'(r_ce), 64'h7);
    chk("oob_lanes_idle", 64'({r_ub, r_lb}), 64'h3F);
    chk("oob_oe_cycles", 64'(oe_c), 64'd0);
    chk("oob_busy", 64'(busy), 64'd2);
    chk("oob_dout_zero", 64'(r_dout), 64'h0);
    chk("oob_addr_err", 64'(addr_err), 64'h1);
    run_txn(32'h0000_0010, 4'h0, 32'h0, r_addr, r_ce, r_ub, r_lb, busy, we_c, oe_c, r_dout, r_idle);
    chk("after_oob_dout", 64'(r_dout), 64'h12BB_5678);
    chk("after_oob_addr_err", 64'(addr_err), 64'h1);
`else
    run_txn(32'h0040_0024, 4'h0, 32'h0, r_addr, r_ce, r_ub, r_lb, busy, we_c, oe_c, r_dout, r_idle);
    chk("wrap_addr", 64'(r_addr), 64'h00009);
    chk("wrap_dout", 64'(r_dout), 64'h7722_F00D);
    chk("wrap_addr_err", 64'(addr_err), 64'h0);
`endif

    // Slow instance: five-cycle access
    addr5 = 32'h0001_2340; stb5 = 1'b1;
    @(negedge clk);
    stb5 = 1'b0;
    p5_busy = 0; p5_oe = 0; p5_prev = '1;
    for (int t = 0; t < 40 && nak5; t++) begin
      p5_busy++;
      if (oe5[1:0] == 2'b00) p5_oe++;
      p5_prev = dout5;
      @(negedge clk);
    end
    chk("ac5_busy", 64'(p5_busy), 64'd5);
    chk("ac5_oe_cycles", 64'(p5_oe), 64'd5);
    chk("ac5_dout_before_e5", 64'(p5_prev), 64'h0);
    chk("ac5_dout", 64'(dout5), 64'h5A50_48D0);
    chk("ac5_idle_after", 64'({ce5, oe5}), 64'h3F);

    chk("no_bus_contention", 64'(contention), 64'd0);
    chk("chip2_deselected", 64'(chip2_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
